// File: rtl/aes256_pkg.sv
// Shared AES unloading types and block geometry constants.
package aes256_pkg;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_BLOCK_W     = 128;
  localparam int BYTE_W          = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    OUT
  } unload_state_t;

endpackage

// File: rtl/aes256_unloading.sv
// Pulls 16 ciphertext bytes from upstream one request at a time and presents
// them MSB-first as a single 128-bit block with a valid/ready handshake.
module aes256_unloading
  import aes256_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pi_enc_done,
  output logic                   po_next_val_req,
  input  logic                   pi_next_val_ready,
  input  logic [BYTE_W-1:0]      pi_data,
  output logic                   po_block_valid,
  output logic [AES_BLOCK_W-1:0] po_block,
  input  logic                   pi_block_ready,
  output logic                   po_busy,
  output logic                   po_timeout_err,
  output logic                   po_spurious_err
);

  localparam int               TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_BYTE = 4'(AES_BLOCK_BYTES - 1);
  localparam logic [6:0]       TOP_LANE  = 7'(AES_BLOCK_W - BYTE_W);

  unload_state_t    state, state_nxt;
  logic [3:0]       byte_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [6:0]       lane_lsb;
  logic             byte_take;
  logic             last_byte;
  logic             tmo_expire;
  logic             spurious;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    byte_take  = 1'b0;
    tmo_expire = 1'b0;
    spurious   = 1'b0;
    last_byte  = (byte_cnt == LAST_BYTE);
    unique case (state)
      IDLE: begin
        spurious = pi_next_val_ready;
        if (pi_enc_done) state_nxt = REQ;
      end
      REQ: begin
        spurious  = pi_next_val_ready;
        state_nxt = WAIT;
      end
      WAIT: begin
        // A byte arriving on the expiry cycle still counts as an answer.
        if (pi_next_val_ready) begin
          byte_take = 1'b1;
          state_nxt = last_byte ? OUT : REQ;
        end else if (tmo_cnt == '0) begin
          tmo_expire = 1'b1;
          state_nxt  = IDLE;
        end
      end
      OUT: begin
        spurious = pi_next_val_ready;
        if (pi_block_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign po_busy        = (state != IDLE);
  assign po_block_valid = (state == OUT);
  assign lane_lsb       = TOP_LANE - {byte_cnt, 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      po_next_val_req <= 1'b0;
      po_block        <= '0;
      byte_cnt        <= '0;
      tmo_cnt         <= '0;
      po_timeout_err  <= 1'b0;
      po_spurious_err <= 1'b0;
    end else begin
      po_next_val_req <= (state_nxt == REQ);
      if (state == IDLE && pi_enc_done) begin
        byte_cnt <= '0;
        po_block <= '0;
      end
      if (state == REQ) tmo_cnt <= TMO_LOAD;
      if (byte_take) begin
        po_block[lane_lsb +: BYTE_W] <= pi_data;
        if (!last_byte) byte_cnt <= byte_cnt + 4'd1;
      end else if (tmo_expire) begin
        po_timeout_err <= 1'b1;
        po_block       <= '0;
        byte_cnt       <= '0;
      end else if (state == WAIT) begin
        tmo_cnt <= tmo_cnt - 1'b1;
      end
      if (spurious) po_spurious_err <= 1'b1;
    end
  end

endmodule
